// File: rtl/noc_demux_if.sv
// rtl/noc_demux_if.sv - flit input and per-channel output bundle for noc_demux
interface noc_demux_if #(
  parameter int FLIT_WIDTH = 32,
  parameter int CHANNELS   = 7
);
  logic [FLIT_WIDTH-1:0] in_flit;
  logic                  in_last;
  logic                  in_valid;
  logic                  in_ready;
  logic [FLIT_WIDTH-1:0] out_flit;
  logic                  out_last;
  logic [CHANNELS-1:0]   out_valid;
  logic [CHANNELS-1:0]   out_ready;
  logic [15:0]           drop_count;

  // master is the demux itself; slave is whatever feeds and drains it
  modport master (
    input  in_flit, in_last, in_valid, out_ready,
    output in_ready, out_flit, out_last, out_valid, drop_count
  );

  modport slave (
    output in_flit, in_last, in_valid, out_ready,
    input  in_ready, out_flit, out_last, out_valid, drop_count
  );
endinterface

// File: rtl/noc_demux.sv
// rtl/noc_demux.sv - wormhole demux: header picks a channel, route held until tail, bad indices dropped
module noc_demux #(
  parameter int FLIT_WIDTH = 32,
  parameter int CHANNELS   = 7,
  parameter int DEST_LSB   = 27,
  parameter int DEST_WIDTH = 5
) (
  input  logic         clk,
  input  logic         rst,
  noc_demux_if.master  bus
);
  localparam int SEL_W = $clog2(CHANNELS);

  typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_t;

  state_t                state, state_nx;
  logic [SEL_W-1:0]      sel, load_sel;
  logic [DEST_WIDTH-1:0] idx;
  logic                  idx_ok, full, drain, can_load, load, drop_inc;

  assign idx      = bus.in_flit[DEST_LSB +: DEST_WIDTH];
  assign idx_ok   = 32'(idx) < 32'(CHANNELS);
  assign full     = |bus.out_valid;
  assign drain    = full & |(bus.out_valid & bus.out_ready);
  assign can_load = ~full | drain;

  always_comb begin
    state_nx     = state;
    bus.in_ready = 1'b0;
    load         = 1'b0;
    drop_inc     = 1'b0;
    load_sel     = sel;
    unique case (state)
      IDLE: begin
        if (idx_ok) begin
          bus.in_ready = can_load;
          load         = bus.in_valid & can_load;
          load_sel     = idx[SEL_W-1:0];
          if (load && !bus.in_last) state_nx = ACTIVE;
        end else begin
          // bad destination: swallowed even while the stage is stalled
          bus.in_ready = 1'b1;
          drop_inc     = bus.in_valid;
          if (bus.in_valid && !bus.in_last) state_nx = DROP;
        end
      end
      ACTIVE: begin
        bus.in_ready = can_load;
        load         = bus.in_valid & can_load;
        if (load && bus.in_last) state_nx = IDLE;
      end
      DROP: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && bus.in_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      sel            <= '0;
      bus.out_valid  <= '0;
      bus.out_flit   <= '0;
      bus.out_last   <= 1'b0;
      bus.drop_count <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        bus.out_flit  <= bus.in_flit;
        bus.out_last  <= bus.in_last;
        bus.out_valid <= CHANNELS'(1) << load_sel;
        if (state == IDLE) sel <= load_sel;
      end else if (drain) begin
        bus.out_valid <= '0;
      end
      if (drop_inc && bus.drop_count != 16'hFFFF)
        bus.drop_count <= bus.drop_count + 16'd1;
    end
  end
endmodule
